// File: rtl/alu_result_checker_if.sv
// ----------------------------------------------------------------------------
// alu_result_checker_if
// Observation stream carrying one ALU transaction {A, B, opcode, result} from
// the ALU side (master) to the result checker (slave) over valid/ready.
//
// Signals:
//   in_valid  master->slave  observation valid
//   in_ready  slave->master  checker accepts observation this cycle
//   in_a      master->slave  operand A
//   in_b      master->slave  operand B
//   in_opcode master->slave  00 AND, 01 OR, 10 NAND, 11 NOR
//   in_result master->slave  ALU result under check
// ----------------------------------------------------------------------------
interface alu_result_checker_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_opcode;
    logic [WIDTH-1:0] in_result;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_opcode,
        output in_result,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_opcode,
        input  in_result,
        output in_ready
    );
endinterface

// File: rtl/alu_result_checker.sv
// ----------------------------------------------------------------------------
// alu_result_checker
// Consumer-side checker for the 2-bit-opcode logic ALU. Each accepted
// observation is recomputed internally and compared against the reported
// result. Over a run of num_vectors observations it counts accepted vectors
// and mismatches, captures the first failing vector and reports pass/fail.
//
// Optional build macro:
//   HALT_ON_FAIL_EN  when defined, the first mismatching transfer ends the run
//                    (that vector is still counted). When undefined, the run
//                    always consumes exactly num_vectors observations.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset (aborts any run, clears all)
//   start           single-cycle pulse starting a run (ignored while busy)
//   num_vectors     vectors to check, latched on start
//   obs             observation stream (slave modport, valid/ready)
//   busy            high while a run is consuming observations
//   done            high once the run has finished; results hold until start
//   pass            valid with done: no mismatches in the run
//   vec_count       vectors accepted this run
//   err_count       mismatches this run, saturating at all-ones
//   first_err_valid a mismatch has been captured this run
//   first_err_idx   vec_count value at the first mismatch (0-based)
//   first_err_exp   expected result of the first mismatch
//   first_err_act   actual result of the first mismatch
// ----------------------------------------------------------------------------
module alu_result_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_vectors,
    alu_result_checker_if.slave  obs,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic                 first_err_valid,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic [WIDTH-1:0]     first_err_exp,
    output logic [WIDTH-1:0]     first_err_act
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reference model of the ALU under check.
    function automatic logic [WIDTH-1:0] alu_model(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = ~(a & b);
            default: r = ~(a | b);
        endcase
        return r;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             fev_q, fev_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [WIDTH-1:0] fexp_q, fexp_d;
    logic [WIDTH-1:0] fact_q, fact_d;
    logic             pass_q, pass_d;

    logic [WIDTH-1:0] exp_res;
    logic             xfer;
    logic             mismatch;
    logic             end_run;
    logic [CNT_W-1:0] vec_inc;

    // Stage p0: combinational compare and next-state decode.
    always_comb begin
        exp_res  = alu_model(obs.in_a, obs.in_b, obs.in_opcode);
        xfer     = (state_q == RUN) && obs.in_valid;
        mismatch = (exp_res != obs.in_result);
        vec_inc  = vec_q + 1'b1;
        end_run  = 1'b0;

        state_d  = state_q;
        target_d = target_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fev_d    = fev_q;
        fidx_d   = fidx_q;
        fexp_d   = fexp_q;
        fact_d   = fact_q;
        pass_d   = pass_q;

        case (state_q)
            IDLE, DONE: begin
                // A start from DONE restarts exactly like one from IDLE.
                if (start) begin
                    target_d = num_vectors;
                    vec_d    = '0;
                    err_d    = '0;
                    fev_d    = 1'b0;
                    fidx_d   = '0;
                    fexp_d   = '0;
                    fact_d   = '0;
                    if (num_vectors == '0) begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                        pass_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (xfer) begin
                    vec_d = vec_inc;
                    if (mismatch) begin
                        err_d = sat_inc(err_q);
                        if (!fev_q) begin
                            fev_d  = 1'b1;
                            fidx_d = vec_q;
                            fexp_d = exp_res;
                            fact_d = obs.in_result;
                        end
                    end
`ifdef HALT_ON_FAIL_EN
                    end_run = (vec_inc == target_q) || mismatch;
`else
                    end_run = (vec_inc == target_q);
`endif
                    if (end_run) begin
                        state_d = DONE;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: state and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            target_q <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            fev_q    <= 1'b0;
            fidx_q   <= '0;
            fexp_q   <= '0;
            fact_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            fev_q    <= fev_d;
            fidx_q   <= fidx_d;
            fexp_q   <= fexp_d;
            fact_q   <= fact_d;
            pass_q   <= pass_d;
        end
    end

    // Handshake and status decode straight from state, so in_ready drops the
    // cycle after the final transfer.
    assign obs.in_ready    = (state_q == RUN);
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign vec_count       = vec_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_q;
    assign first_err_idx   = fidx_q;
    assign first_err_exp   = fexp_q;
    assign first_err_act   = fact_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// ----------------------------------------------------------------------------
// tb_alu_result_checker
// Directed self-checking bench for alu_result_checker. Expected values are
// hand-computed: with A=CC, B=AA the ALU gives AND 88, OR EE, NAND 77, NOR 11.
// Build with or without HALT_ON_FAIL_EN; expectations follow the macro.
// ----------------------------------------------------------------------------
module tb_alu_result_checker;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic             busy, done, pass;
    logic [CNT_W-1:0] vec_count, err_count, first_err_idx;
    logic             first_err_valid;
    logic [WIDTH-1:0] first_err_exp, first_err_act;

    int n_checks = 0;
    int n_pass   = 0;

    alu_result_checker_if #(.WIDTH(WIDTH)) obs ();

    alu_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .num_vectors     (num_vectors),
        .obs             (obs),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .vec_count       (vec_count),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx),
        .first_err_exp   (first_err_exp),
        .first_err_act   (first_err_act)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [CNT_W-1:0] n);
        start       = 1'b1;
        num_vectors = n;
        tick();
        start       = 1'b0;
    endtask

    task automatic send_vec(input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] op, input logic [7:0] r);
        int waited;
        waited        = 0;
        obs.in_valid  = 1'b1;
        obs.in_a      = a;
        obs.in_b      = b;
        obs.in_opcode = op;
        obs.in_result = r;
        while (!obs.in_ready && waited < 8) begin
            tick();
            waited++;
        end
        if (!obs.in_ready) check("ready_timeout", 32'd0, 32'd1);
        tick();
        obs.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_vectors = '0;
        obs.in_valid = 1'b0; obs.in_a = '0; obs.in_b = '0;
        obs.in_opcode = '0; obs.in_result = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_ready", obs.in_ready, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_pass",  pass, 0);
        check("rst_vec",   vec_count, 0);
        check("rst_err",   err_count, 0);
        check("rst_fev",   first_err_valid, 0);

        // Clean run of 4 back-to-back vectors
        start_run(8'd4);
        check("t1_busy",  busy, 1);
        check("t1_ready", obs.in_ready, 1);
        send_vec(8'hCC, 8'hAA, 2'b00, 8'h88);
        send_vec(8'hCC, 8'hAA, 2'b01, 8'hEE);
        check("t1_vec_mid", vec_count, 2);
        send_vec(8'hCC, 8'hAA, 2'b10, 8'h77);
        send_vec(8'hCC, 8'hAA, 2'b11, 8'h11);
        check("t1_ready_low", obs.in_ready, 0);
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_pass", pass, 1);
        check("t1_vec",  vec_count, 4);
        check("t1_err",  err_count, 0);

        // Restart from DONE; NAND result wrong (76 instead of 77)
        start_run(8'd4);
        check("t2_restart_busy", busy, 1);
        check("t2_restart_vec", vec_count, 0);
        send_vec(8'hCC, 8'hAA, 2'b00, 8'h88);
        send_vec(8'hCC, 8'hAA, 2'b01, 8'hEE);
        send_vec(8'hCC, 8'hAA, 2'b10, 8'h76);
`ifdef HALT_ON_FAIL_EN
        check("t2_halt_done", done, 1);
        check("t2_halt_ready", obs.in_ready, 0);
        check("t2_vec", vec_count, 3);
`else
        check("t2_still_busy", busy, 1);
        send_vec(8'hCC, 8'hAA, 2'b11, 8'h11);
        check("t2_vec", vec_count, 4);
`endif
        check("t2_done", done, 1);
        check("t2_err",  err_count, 1);
        check("t2_fev",  first_err_valid, 1);
        check("t2_fidx", first_err_idx, 2);
        check("t2_fexp", first_err_exp, 8'h77);
        check("t2_fact", first_err_act, 8'h76);
        check("t2_pass", pass, 0);

        // Two mismatches: the first one stays captured
        start_run(8'd3);
        check("t2b_cleared_err", err_count, 0);
        check("t2b_cleared_fev", first_err_valid, 0);
        send_vec(8'hCC, 8'hAA, 2'b01, 8'hEF);
`ifdef HALT_ON_FAIL_EN
        check("t2b_done", done, 1);
        check("t2b_vec", vec_count, 1);
        check("t2b_err", err_count, 1);
`else
        send_vec(8'hCC, 8'hAA, 2'b00, 8'h88);
        send_vec(8'hCC, 8'hAA, 2'b11, 8'h10);
        check("t2b_done", done, 1);
        check("t2b_vec", vec_count, 3);
        check("t2b_err", err_count, 2);
`endif
        check("t2b_fidx", first_err_idx, 0);
        check("t2b_fexp", first_err_exp, 8'hEE);
        check("t2b_fact", first_err_act, 8'hEF);

        // in_valid toggled 1,0,1,0 with 2 vectors
        start_run(8'd2);
        obs.in_valid = 1'b1; obs.in_opcode = 2'b00; obs.in_result = 8'h88;
        obs.in_a = 8'hCC; obs.in_b = 8'hAA;
        tick();
        obs.in_valid = 1'b0;
        tick();
        check("t3_vec_gap", vec_count, 1);
        check("t3_busy_gap", busy, 1);
        obs.in_valid = 1'b1; obs.in_opcode = 2'b11; obs.in_result = 8'h11;
        tick();
        obs.in_valid = 1'b0;
        check("t3_done", done, 1);
        check("t3_vec", vec_count, 2);
        check("t3_pass", pass, 1);
        obs.in_valid = 1'b1;
        tick();
        obs.in_valid = 1'b0;
        check("t3_ignore_valid_vec", vec_count, 2);
        check("t3_ignore_valid_done", done, 1);

        // Zero-length run
        start_run(8'd0);
        check("t4_done", done, 1);
        check("t4_pass", pass, 1);
        check("t4_vec", vec_count, 0);
        check("t4_ready", obs.in_ready, 0);
        check("t4_busy", busy, 0);

        // Reset mid-run after 2 of 4 vectors (second one wrong)
        start_run(8'd4);
        send_vec(8'hCC, 8'hAA, 2'b00, 8'h88);
        send_vec(8'hCC, 8'hAA, 2'b01, 8'h00);
        check("t5_pre_err", err_count, 1);
        check("t5_pre_fev", first_err_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_ready", obs.in_ready, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_pass", pass, 0);
        check("t5_vec", vec_count, 0);
        check("t5_err", err_count, 0);
        check("t5_fev", first_err_valid, 0);
        check("t5_fidx", first_err_idx, 0);
        check("t5_fexp", first_err_exp, 0);
        check("t5_fact", first_err_act, 0);
        start_run(8'd1);
        send_vec(8'hCC, 8'hAA, 2'b10, 8'h77);
        check("t5_rerun_done", done, 1);
        check("t5_rerun_pass", pass, 1);
        check("t5_rerun_vec", vec_count, 1);

        // start mid-RUN is ignored (latched count stays 3)
        start_run(8'd3);
        send_vec(8'hCC, 8'hAA, 2'b00, 8'h88);
        start_run(8'd1);
        check("t6_busy", busy, 1);
        check("t6_vec", vec_count, 1);
        send_vec(8'hCC, 8'hAA, 2'b01, 8'hEE);
        check("t6_not_done", done, 0);
        send_vec(8'hCC, 8'hAA, 2'b11, 8'h11);
        check("t6_done", done, 1);
        check("t6_vec_final", vec_count, 3);
        check("t6_pass", pass, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
